vga_frame_monitor: RTL and testbench

VGA_FRAME_MONITOR -- requirements
Module: vga_frame_monitor

---
 rtl/vga_frame_monitor.sv | 159 +++++++++++++++
 tb/tb_vga_frame_monitor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_monitor.sv
// VGA frame monitor: measures line/frame timing and green pixel count,
// tracks lock against H_TOTAL/V_TOTAL, and emits a valid/ready frame report.
// Ports:
//   clk, rst_n            pixel clock, async active-low reset
//   hsync, vsync, rgb_in  active-low syncs and pixel data from timing stage
//   report_ready          downstream accepts report
//   report_valid          frame report available
//   line_len              clocks per line, last line of reported frame
//   frame_lines           lines in reported frame
//   green_cnt             GREEN_VAL pixels in reported frame
//   locked                timing matches H_TOTAL/V_TOTAL
//   err                   one-cycle pulse on entry to ERROR
//   overrun               sticky: a report was dropped under backpressure
module vga_frame_monitor #(
   parameter int unsigned H_TOTAL   = 800,
   parameter int unsigned V_TOTAL   = 525,
   parameter logic [7:0]  GREEN_VAL = 8'b000_111_00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [7:0]  rgb_in,
   input  logic        report_ready,
   output logic        report_valid,
   output logic [9:0]  line_len,
   output logic [9:0]  frame_lines,
   output logic [17:0] green_cnt,
   output logic        locked,
   output logic        err,
   output logic        overrun
);

   typedef enum logic [1:0] {HUNT, MEASURE, LOCKED, ERROR} state_t;

   localparam logic [9:0] H_CHK = 10'(H_TOTAL);
   localparam logic [9:0] V_CHK = 10'(V_TOTAL);

   state_t      state, state_nxt;
   logic        hs_r, vs_r, hs_p, vs_p;
   logic [7:0]  rgb_r;
   logic        hs_fe, vs_fe, grn_fe;
   logic [9:0]  lcnt, fcnt, last_int, intv;
   logic [17:0] gcnt;
   logic        skip, bad;
   logic [9:0]  snap_len, snap_lines;
   logic [17:0] snap_green;
   logic        ld;
   logic        h_bad, v_bad, enter_err;

   // Input register plus one event stage; the event stage sets the
   // report latency so that report_valid rises three edges after vsync
   // is first sampled low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_r   <= 1'b1;
         vs_r   <= 1'b1;
         hs_p   <= 1'b1;
         vs_p   <= 1'b1;
         rgb_r  <= '0;
         hs_fe  <= 1'b0;
         vs_fe  <= 1'b0;
         grn_fe <= 1'b0;
      end else begin
         hs_r   <= hsync;
         vs_r   <= vsync;
         hs_p   <= hs_r;
         vs_p   <= vs_r;
         rgb_r  <= rgb_in;
         hs_fe  <= hs_p & ~hs_r;
         vs_fe  <= vs_p & ~vs_r;
         grn_fe <= (rgb_r == GREEN_VAL);
      end
   end

   // Interval ending at this hsync fall, saturated at 1023.
   assign intv  = (lcnt == 10'h3ff) ? lcnt : lcnt + 10'd1;
   assign h_bad = hs_fe && !skip && (intv != H_CHK);
   assign v_bad = (fcnt != V_CHK);

   always_comb begin
      state_nxt = state;
      unique case (state)
         HUNT:    if (vs_fe) state_nxt = MEASURE;
         MEASURE: if (vs_fe) state_nxt = (bad || h_bad || v_bad) ? ERROR : LOCKED;
         LOCKED:  if (h_bad || (vs_fe && v_bad)) state_nxt = ERROR;
         ERROR:   if (vs_fe) state_nxt = MEASURE;
      endcase
      enter_err = (state_nxt == ERROR) && (state != ERROR);
   end

   assign locked = (state == LOCKED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= HUNT;
         lcnt     <= '0;
         fcnt     <= '0;
         gcnt     <= '0;
         last_int <= '0;
         skip     <= 1'b1;
         bad      <= 1'b0;
         err      <= 1'b0;
      end else begin
         state <= state_nxt;
         err   <= enter_err;
         lcnt  <= hs_fe ? 10'd0 : intv;
         if (hs_fe) last_int <= intv;
         // Partial line from hunting is never checked.
         if (state == HUNT) skip <= 1'b1;
         else if (hs_fe)    skip <= 1'b0;
         if (state != MEASURE) bad <= 1'b0;
         else if (h_bad)       bad <= 1'b1;
         // A coincident hsync fall opens the new frame.
         if (vs_fe)      fcnt <= {9'd0, hs_fe};
         else if (hs_fe) fcnt <= (fcnt == 10'h3ff) ? fcnt : fcnt + 10'd1;
         if (vs_fe)       gcnt <= '0;
         else if (grn_fe) gcnt <= (gcnt == 18'h3ffff) ? gcnt : gcnt + 18'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_len   <= '0;
         snap_lines <= '0;
         snap_green <= '0;
         ld         <= 1'b0;
      end else begin
         ld <= vs_fe && (state != HUNT);
         if (vs_fe) begin
            snap_len   <= hs_fe ? intv : last_int;
            snap_lines <= fcnt;
            snap_green <= gcnt;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         report_valid <= 1'b0;
         line_len     <= '0;
         frame_lines  <= '0;
         green_cnt    <= '0;
         overrun      <= 1'b0;
      end else if (ld) begin
         if (!report_valid || report_ready) begin
            report_valid <= 1'b1;
            line_len     <= snap_len;
            frame_lines  <= snap_lines;
            green_cnt    <= snap_green;
         end else begin
            overrun <= 1'b1;
         end
      end else if (report_ready) begin
         report_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor on a scaled 64x24 raster.
// Lines: hsync low clocks 8..19; vsync low lines 0..1; green square 10x10.
module tb_vga_frame_monitor;

   localparam logic [7:0] GRN = 8'b000_111_00;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hsync, vsync;
   logic [7:0]  rgb_in;
   logic        report_ready;
   logic        report_valid;
   logic [9:0]  line_len, frame_lines;
   logic [17:0] green_cnt;
   logic        locked, err, overrun;

   int checks = 0;
   int failures = 0;

   int cyc = 0;
   int vs_cyc = 0;
   int lat = -1;
   int xfers = 0;
   int err_cnt = 0;
   logic       vs_prev = 1'b1;
   logic       rv_prev = 1'b0;
   logic [9:0]  x_len = '0;
   logic [9:0]  x_lines = '0;
   logic [17:0] x_green = '0;

   vga_frame_monitor #(
      .H_TOTAL(64),
      .V_TOTAL(24),
      .GREEN_VAL(GRN)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .hsync(hsync),
      .vsync(vsync),
      .rgb_in(rgb_in),
      .report_ready(report_ready),
      .report_valid(report_valid),
      .line_len(line_len),
      .frame_lines(frame_lines),
      .green_cnt(green_cnt),
      .locked(locked),
      .err(err),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      vs_prev <= vsync;
      if (!vsync && vs_prev) vs_cyc <= cyc;
      if (rst_n && report_valid && report_ready) begin
         xfers   <= xfers + 1;
         x_len   <= line_len;
         x_lines <= frame_lines;
         x_green <= green_cnt;
      end
      if (err) err_cnt <= err_cnt + 1;
   end

   always @(negedge clk) begin
      if (report_valid && !rv_prev) lat <= cyc - 1 - vs_cyc;
      rv_prev <= report_valid;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive_line(input int idx, input int len,
                             input bit coinc, input int glast);
      for (int c = 0; c < len; c++) begin
         @(negedge clk);
         hsync = !(c >= 8 && c < 20);
         if (coinc)
            vsync = !((idx == 0 && c >= 8) || idx == 1 || (idx == 2 && c < 8));
         else
            vsync = !(idx < 2);
         rgb_in = (idx >= 4 && idx <= glast && c >= 24 && c < 34) ? GRN : 8'h03;
      end
   endtask

   task automatic frame(input int first, input int last, input int short_idx,
                        input bit coinc, input int glast);
      for (int i = first; i <= last; i++)
         drive_line(i, (i == short_idx) ? 63 : 64, coinc, glast);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, report_valid, 0);
      chk({tag, "_len"}, line_len, 0);
      chk({tag, "_lines"}, frame_lines, 0);
      chk({tag, "_green"}, green_cnt, 0);
      chk({tag, "_locked"}, locked, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_overrun"}, overrun, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      hsync = 1'b1;
      vsync = 1'b1;
      rgb_in = 8'h00;
      report_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1 chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // F0: leaves HUNT, nothing reported yet.
      frame(0, 23, -1, 1'b0, 13);
      chk("f0_locked", locked, 0);
      chk("f0_xfers", xfers, 0);
      // F1 start closes F0: lock and first report.
      frame(0, 23, -1, 1'b0, 13);
      chk("f1_locked", locked, 1);
      chk("f1_xfers", xfers, 1);
      chk("f1_len", x_len, 64);
      chk("f1_lines", x_lines, 24);
      chk("f1_green", x_green, 100);
      chk("f1_latency", lat, 3);
      chk("f1_err", err_cnt, 0);

      // F2 has one 63-clock line: error while locked.
      frame(0, 23, 10, 1'b0, 13);
      chk("short_err", err_cnt, 1);
      chk("short_locked", locked, 0);
      frame(0, 23, -1, 1'b0, 13);
      chk("f3_locked", locked, 0);
      chk("f3_len", x_len, 64);
      chk("f3_lines", x_lines, 24);
      // F4 smaller square to tag its report.
      frame(0, 23, -1, 1'b0, 8);
      chk("relock", locked, 1);
      chk("f4_xfers", xfers, 4);

      // Backpressure over three frame ends.
      report_ready = 1'b0;
      frame(0, 23, -1, 1'b0, 13);
      chk("bp1_valid", report_valid, 1);
      chk("bp1_green", green_cnt, 50);
      chk("bp1_overrun", overrun, 0);
      frame(0, 23, -1, 1'b0, 13);
      chk("bp2_overrun", overrun, 1);
      chk("bp2_green", green_cnt, 50);
      frame(0, 9, -1, 1'b0, 13);
      chk("bp3_green", green_cnt, 50);
      chk("bp3_xfers", xfers, 4);
      report_ready = 1'b1;
      frame(10, 14, -1, 1'b0, 13);
      chk("bp_xfers", xfers, 5);
      chk("bp_xgreen", x_green, 50);
      chk("bp_valid", report_valid, 0);
      chk("bp_overrun_sticky", overrun, 1);

      // Report pending when reset hits mid-frame.
      report_ready = 1'b0;
      frame(15, 23, -1, 1'b0, 13);
      frame(0, 5, -1, 1'b0, 13);
      chk("pend_valid", report_valid, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1 chk_zero("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      report_ready = 1'b1;
      frame(6, 23, -1, 1'b0, 13);
      frame(0, 23, -1, 1'b0, 13);
      chk("rr_xfers1", xfers, 5);
      chk("rr_valid", report_valid, 0);
      chk("rr_locked", locked, 0);
      frame(0, 23, -1, 1'b0, 13);
      chk("rr_xfers2", xfers, 6);
      chk("rr_lines", x_lines, 24);
      chk("rr_locked2", locked, 1);

      // 23-line frame after lock.
      frame(0, 22, -1, 1'b0, 13);
      frame(0, 23, -1, 1'b0, 13);
      chk("short_frame_err", err_cnt, 2);
      chk("short_frame_locked", locked, 0);
      chk("short_frame_lines", frame_lines, 23);
      chk("short_frame_xlines", x_lines, 23);

      // Coincident hsync/vsync falls.
      frame(0, 23, -1, 1'b1, 13);
      chk("co1_lines", x_lines, 24);
      frame(0, 23, -1, 1'b1, 13);
      chk("co2_locked", locked, 1);
      chk("co2_lines", x_lines, 24);
      frame(0, 23, -1, 1'b1, 13);
      chk("co3_locked", locked, 1);
      chk("co3_err", err_cnt, 2);
      chk("co3_lines", x_lines, 24);
      chk("co3_len", x_len, 64);
      chk("co3_xfers", xfers, 11);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
